alu_arbiter: RTL and testbench

Shares the single 8-bit ALU between two requesters, e.g. the instruction datapath (port 0) and a secondary unit such as a test/DMA engine (port 1). It provides a valid/ready handshake per requester with round-robin arbitration. It registers the winning operands onto the ALU inputs and holds them for a per-opcode settling time. It then returns RESULT/ZERO to the requester that issued the operation. It sits between the requesters and the `alu` instance and is the only driver of the ALU's DATA1/DATA2/SELECT.

---
 rtl/alu_arbiter.sv | 146 ++++++++++++++
 tb/tb_alu_arbiter.sv | 292 +++++++++++++++++++++++++++++
 2 files changed

// File: rtl/alu_arbiter.sv
// Round-robin valid/ready arbiter that shares one 8-bit ALU between two
// requesters and returns each result to the requester that issued it.
module alu_arbiter #(
  parameter int unsigned MULT_CYCLES = 2
) (
  input  logic       CLK,
  input  logic       RESET,
  input  logic       REQ0_VALID,
  input  logic [2:0] REQ0_SELECT,
  input  logic [7:0] REQ0_DATA1,
  input  logic [7:0] REQ0_DATA2,
  output logic       REQ0_READY,
  input  logic       REQ1_VALID,
  input  logic [2:0] REQ1_SELECT,
  input  logic [7:0] REQ1_DATA1,
  input  logic [7:0] REQ1_DATA2,
  output logic       REQ1_READY,
  output logic       RSP0_VALID,
  output logic [7:0] RSP0_RESULT,
  output logic       RSP0_ZERO,
  output logic       RSP0_ERR,
  output logic       RSP1_VALID,
  output logic [7:0] RSP1_RESULT,
  output logic       RSP1_ZERO,
  output logic       RSP1_ERR,
  output logic [7:0] ALU_DATA1,
  output logic [7:0] ALU_DATA2,
  output logic [2:0] ALU_SELECT,
  input  logic [7:0] ALU_RESULT,
  input  logic       ALU_ZERO
);

  typedef enum logic [1:0] {
    IDLE,
    EXEC,
    RESP
  } state_t;

  typedef struct packed {
    logic [2:0] sel;
    logic [7:0] d1;
    logic [7:0] d2;
  } op_t;

  localparam logic [3:0] MC_LD = 4'(MULT_CYCLES - 1);

  state_t          state;
  state_t          state_nx;
  logic            last;
  logic            owner;
  logic            gnt;
  logic            fire;
  logic            illegal;
  logic            slow;
  logic [3:0]      cnt;
  op_t             op;
  logic [1:0][7:0] rsp_res;
  logic [1:0]      rsp_zero;
  logic [1:0]      rsp_err;

  // On a tie the port that did not win last time gets the grant.
  always_comb begin
    gnt = 1'b0;
    unique case (1'b1)
      REQ0_VALID && REQ1_VALID:  gnt = ~last;
      REQ1_VALID && !REQ0_VALID: gnt = 1'b1;
      default:                   gnt = 1'b0;
    endcase
  end

  assign op = gnt ? {REQ1_SELECT, REQ1_DATA1, REQ1_DATA2}
                  : {REQ0_SELECT, REQ0_DATA1, REQ0_DATA2};

  assign illegal = op.sel[2] & op.sel[1];
  assign slow    = op.sel[2] & ~op.sel[1];
  assign fire    = (state == IDLE) && (REQ0_VALID || REQ1_VALID) && RESET;

  always_ff @(posedge CLK or negedge RESET) begin
    if (!RESET) state <= IDLE;
    else        state <= state_nx;
  end

  always_comb begin
    state_nx = state;
    unique case (state)
      IDLE: if (fire) state_nx = illegal ? RESP : EXEC;
      EXEC: if (cnt == 4'd0) state_nx = RESP;
      RESP: state_nx = IDLE;
      default: state_nx = IDLE;
    endcase
  end

  always_comb begin
    REQ0_READY = fire && !gnt;
    REQ1_READY = fire && gnt;
    RSP0_VALID = (state == RESP) && !owner;
    RSP1_VALID = (state == RESP) && owner;
  end

  assign RSP0_RESULT = rsp_res[0];
  assign RSP0_ZERO   = rsp_zero[0];
  assign RSP0_ERR    = rsp_err[0];
  assign RSP1_RESULT = rsp_res[1];
  assign RSP1_ZERO   = rsp_zero[1];
  assign RSP1_ERR    = rsp_err[1];

  always_ff @(posedge CLK or negedge RESET) begin
    if (!RESET) begin
      last       <= 1'b1;
      owner      <= 1'b0;
      cnt        <= 4'd0;
      ALU_SELECT <= 3'd0;
      ALU_DATA1  <= 8'h00;
      ALU_DATA2  <= 8'h00;
    end else if (fire) begin
      owner <= gnt;
      last  <= gnt;
      cnt   <= slow ? MC_LD : 4'd0;
      if (!illegal) begin
        ALU_SELECT <= op.sel;
        ALU_DATA1  <= op.d1;
        ALU_DATA2  <= op.d2;
      end
    end else if (state == EXEC && cnt != 4'd0) begin
      cnt <= cnt - 4'd1;
    end
  end

  // Illegal opcodes never touch the ALU; their error response is set here.
  always_ff @(posedge CLK or negedge RESET) begin
    if (!RESET) begin
      rsp_res  <= '0;
      rsp_zero <= 2'b00;
      rsp_err  <= 2'b00;
    end else if (fire && illegal) begin
      rsp_res[gnt]  <= 8'h00;
      rsp_zero[gnt] <= 1'b0;
      rsp_err[gnt]  <= 1'b1;
    end else if (state == EXEC && cnt == 4'd0) begin
      rsp_res[owner]  <= ALU_RESULT;
      rsp_zero[owner] <= ALU_ZERO;
      rsp_err[owner]  <= 1'b0;
    end
  end

endmodule

// File: tb/tb_alu_arbiter.sv
// Bench for alu_arbiter: directed handshake/latency/reset checks followed
// by randomized contention checked against a behavioural reference model.
module tb_alu_arbiter;

  localparam int MC = 2;

  logic       CLK = 1'b0;
  logic       RESET = 1'b0;
  logic [1:0] vld = 2'b00;
  logic [2:0] sel [2];
  logic [7:0] d1 [2];
  logic [7:0] d2 [2];
  logic [1:0] rdy;
  logic [1:0] rvld;
  logic [7:0] rres [2];
  logic [1:0] rzero;
  logic [1:0] rerr;
  logic [7:0] ALU_DATA1;
  logic [7:0] ALU_DATA2;
  logic [2:0] ALU_SELECT;
  logic [7:0] ALU_RESULT;
  logic       ALU_ZERO;

  int tests = 0;
  int fails = 0;
  logic [18:0] exp_alu = '0;

  always #5 CLK = ~CLK;

  alu_arbiter #(.MULT_CYCLES(MC)) dut (
    .CLK(CLK), .RESET(RESET),
    .REQ0_VALID(vld[0]), .REQ0_SELECT(sel[0]),
    .REQ0_DATA1(d1[0]), .REQ0_DATA2(d2[0]), .REQ0_READY(rdy[0]),
    .REQ1_VALID(vld[1]), .REQ1_SELECT(sel[1]),
    .REQ1_DATA1(d1[1]), .REQ1_DATA2(d2[1]), .REQ1_READY(rdy[1]),
    .RSP0_VALID(rvld[0]), .RSP0_RESULT(rres[0]),
    .RSP0_ZERO(rzero[0]), .RSP0_ERR(rerr[0]),
    .RSP1_VALID(rvld[1]), .RSP1_RESULT(rres[1]),
    .RSP1_ZERO(rzero[1]), .RSP1_ERR(rerr[1]),
    .ALU_DATA1(ALU_DATA1), .ALU_DATA2(ALU_DATA2), .ALU_SELECT(ALU_SELECT),
    .ALU_RESULT(ALU_RESULT), .ALU_ZERO(ALU_ZERO)
  );

  // Reference ALU behaviour; SHIFT_ROTATE is taken as rotate-left by DATA2[2:0].
  function automatic logic [7:0] ref_res(logic [2:0] s, logic [7:0] a, logic [7:0] b);
    int r;
    int k;
    case (s)
      3'd0: r = int'(b);
      3'd1: r = int'(a) + int'(b);
      3'd2: r = int'(a & b);
      3'd3: r = int'(a | b);
      3'd4: r = int'(a) * int'(b);
      3'd5: begin
        k = int'(b) % 8;
        r = (int'(a) << k) | (int'(a) >> (8 - k));
      end
      default: r = 0;
    endcase
    return r[7:0];
  endfunction

  always_comb begin
    ALU_RESULT = ref_res(ALU_SELECT, ALU_DATA1, ALU_DATA2);
    ALU_ZERO   = (ALU_RESULT == 8'h00);
  end

  task automatic chk(string tag, logic [31:0] obs, logic [31:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge CLK);
    #1;
  endtask

  task automatic do_op(int p, logic [2:0] s, logic [7:0] a, logic [7:0] b, string tag);
    int k;
    int lat;
    logic ill;
    logic [7:0] er;
    ill = (s >= 3'd6);
    lat = ill ? 1 : ((s == 3'd4 || s == 3'd5) ? MC + 1 : 2);
    er  = ill ? 8'h00 : ref_res(s, a, b);
    sel[p] = s;
    d1[p]  = a;
    d2[p]  = b;
    vld[p] = 1'b1;
    #1;
    k = 0;
    while (!rdy[p] && k < 20) begin
      step();
      k++;
    end
    chk({tag, "_ready"}, 32'(rdy[p]), 32'd1);
    step();
    vld[p] = 1'b0;
    k = 1;
    if (ill) begin
      chk({tag, "_alu_hold"}, 32'({ALU_SELECT, ALU_DATA1, ALU_DATA2}), 32'(exp_alu));
    end else begin
      exp_alu = {s, a, b};
      chk({tag, "_alu_in"}, 32'({ALU_SELECT, ALU_DATA1, ALU_DATA2}), 32'(exp_alu));
    end
    while (!rvld[p] && k < 20) begin
      step();
      k++;
    end
    chk({tag, "_latency"}, 32'(k), 32'(lat));
    chk({tag, "_result"}, 32'(rres[p]), 32'(er));
    chk({tag, "_zero"}, 32'(rzero[p]), 32'(!ill && er == 8'h00));
    chk({tag, "_err"}, 32'(rerr[p]), 32'(ill));
    chk({tag, "_other_vld"}, 32'(rvld[1-p]), 32'd0);
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog timeout");
    $fatal(1, "watchdog");
  end

  initial begin
    int cyc;
    int pend;
    int pend_p;
    int pend_cyc;
    int idle_at;
    int hs_p;
    int last_g;
    int g;
    int lat;
    int done;
    int cntp [2];
    logic [7:0] pend_res;
    logic pend_err;
    logic [1:0] exp_mask;
    logic [1:0] exp_rdy;

    for (int i = 0; i < 2; i++) begin
      sel[i] = 3'd0;
      d1[i]  = 8'h00;
      d2[i]  = 8'h00;
    end

    // Reset state, with a requester already asserting VALID
    vld[0] = 1'b1;
    repeat (2) @(posedge CLK);
    #1;
    chk("rst_ready", 32'(rdy), 32'd0);
    chk("rst_alu", 32'({ALU_SELECT, ALU_DATA1, ALU_DATA2}), 32'd0);
    chk("rst_rsp_vld", 32'(rvld), 32'd0);
    chk("rst_rsp", 32'({rres[0], rres[1], rzero, rerr}), 32'd0);
    vld[0] = 1'b0;
    RESET  = 1'b1;
    step();

    do_op(0, 3'd1, 8'h05, 8'h03, "add");
    do_op(0, 3'd0, 8'h5A, 8'h00, "fwd_zero");
    do_op(1, 3'd1, 8'hFF, 8'h01, "add_wrap");
    do_op(1, 3'd4, 8'h07, 8'h09, "mult");
    do_op(0, 3'd5, 8'h81, 8'h03, "rot");
    do_op(1, 3'd6, 8'hAA, 8'hBB, "ill6");
    do_op(0, 3'd7, 8'h12, 8'h34, "ill7");
    do_op(0, 3'd2, 8'hF3, 8'h3C, "and");

    // Simultaneous requests right after reset
    RESET = 1'b0;
    step();
    RESET   = 1'b1;
    exp_alu = '0;
    sel[0] = 3'd4; d1[0] = 8'h04; d2[0] = 8'h03;
    sel[1] = 3'd3; d1[1] = 8'hF0; d2[1] = 8'h0F;
    vld = 2'b11;
    #1;
    chk("sim_ready_T", 32'(rdy), 32'b01);
    step();
    vld[0] = 1'b0;
    step();
    chk("sim_rsp0_T2", 32'(rvld), 32'd0);
    step();
    chk("sim_rsp0_T3", 32'(rvld), 32'b01);
    chk("sim_res0", 32'(rres[0]), 32'h0C);
    step();
    chk("sim_ready1_T4", 32'(rdy), 32'b10);
    step();
    vld[1] = 1'b0;
    chk("sim_alu_sel", 32'(ALU_SELECT), 32'd3);
    step();
    chk("sim_rsp1_T6", 32'(rvld), 32'b10);
    chk("sim_res1", 32'(rres[1]), 32'hFF);
    chk("sim_zero1", 32'(rzero[1]), 32'd0);

    // Reset during EXEC of a MULT
    sel[0] = 3'd4; d1[0] = 8'h06; d2[0] = 8'h07;
    vld[0] = 1'b1;
    step();
    chk("abort_ready", 32'(rdy), 32'b01);
    step();
    vld[0] = 1'b0;
    RESET  = 1'b0;
    #1;
    chk("abort_alu", 32'({ALU_SELECT, ALU_DATA1, ALU_DATA2}), 32'd0);
    chk("abort_rsp", 32'({rres[0], rres[1], rzero, rerr}), 32'd0);
    for (int i = 0; i < 3; i++) begin
      chk("abort_no_pulse", 32'(rvld), 32'd0);
      step();
    end
    RESET = 1'b1;
    vld   = 2'b11;
    #1;
    chk("abort_tie", 32'(rdy), 32'b01);
    vld = 2'b00;
    step();

    // Randomized contention against the reference model
    cntp[0] = 0;
    cntp[1] = 0;
    for (int i = 0; i < 2; i++) begin
      sel[i] = 3'($urandom_range(0, 7));
      d1[i]  = 8'($urandom);
      d2[i]  = 8'($urandom);
    end
    vld      = 2'b11;
    pend     = 0;
    pend_p   = 0;
    pend_cyc = 0;
    pend_res = 8'h00;
    pend_err = 1'b0;
    idle_at  = 0;
    hs_p     = -1;
    last_g   = 1;
    done     = 0;
    cyc      = 0;
    while ((done < 12 || pend != 0) && cyc < 300) begin
      exp_mask = 2'b00;
      if (pend != 0 && cyc == pend_cyc) exp_mask[pend_p] = 1'b1;
      chk("rnd_rsp_vld", 32'(rvld), 32'(exp_mask));
      if (exp_mask != 2'b00) begin
        chk("rnd_result", 32'(rres[pend_p]), 32'(pend_res));
        chk("rnd_zero", 32'(rzero[pend_p]), 32'(!pend_err && pend_res == 8'h00));
        chk("rnd_err", 32'(rerr[pend_p]), 32'(pend_err));
        pend    = 0;
        idle_at = cyc + 1;
      end
      if (hs_p >= 0) begin
        if (cntp[hs_p] < 6) begin
          sel[hs_p] = 3'($urandom_range(0, 7));
          d1[hs_p]  = 8'($urandom);
          d2[hs_p]  = 8'($urandom);
        end else begin
          vld[hs_p] = 1'b0;
        end
        hs_p = -1;
      end
      #1;
      exp_rdy = 2'b00;
      g = 0;
      if (pend == 0 && cyc >= idle_at && vld != 2'b00) begin
        g = (vld == 2'b11) ? 1 - last_g : (vld[1] ? 1 : 0);
        exp_rdy[g] = 1'b1;
      end
      chk("rnd_ready", 32'(rdy), 32'(exp_rdy));
      if (exp_rdy != 2'b00) begin
        pend_err = (sel[g] >= 3'd6);
        pend_res = pend_err ? 8'h00 : ref_res(sel[g], d1[g], d2[g]);
        lat = pend_err ? 1 : ((sel[g] == 3'd4 || sel[g] == 3'd5) ? MC + 1 : 2);
        pend_cyc = cyc + lat;
        pend_p = g;
        pend   = 1;
        last_g = g;
        hs_p   = g;
        cntp[g]++;
        done++;
      end
      step();
      cyc++;
    end
    chk("rnd_completed", 32'(done), 32'd12);
    chk("rnd_port0_ops", 32'(cntp[0]), 32'd6);
    chk("rnd_port1_ops", 32'(cntp[1]), 32'd6);
    vld = 2'b00;
    step();

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
